// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: fetch entry record, exception code, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam logic [5:0] ECODE_ADEF = 6'h08;

    // One buffered fetch result, as presented to the IF/ID register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_exc;
        logic [5:0]  ecode;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-port and downstream-handshake bundle for the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: allow_in from the IF/ID register; addr_ok/data_ok from the instruction bus.
// master: fetch stage side. slave: bus model / downstream side.
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        allow_in;
    logic        valid_out;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_is_exc;
    logic [5:0]  out_ecode;

    modport master (
        output inst_req, inst_addr, valid_out, out_pc, out_inst, out_is_exc, out_ecode,
        input  inst_addr_ok, inst_data_ok, inst_rdata, allow_in
    );

    modport slave (
        input  inst_req, inst_addr, valid_out, out_pc, out_inst, out_is_exc, out_ecode,
        output inst_addr_ok, inst_data_ok, inst_rdata, allow_in
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small registered FIFO of fetch entries with synchronous clear.
// Latency: push at edge N is visible at head after edge N (count/head registered).
// Backpressure: none internally; caller must only push when count < DEPTH.
// Ports: aclk/aresetn, clear (drops contents and same-cycle push/pop), push/push_dat, pop, head, count.
module fetch_stage_fifo
    import fetch_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Head reads as all-zero when empty so the outputs are clean after reset/flush.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Pre-ID fetch stage: PC generation, single-outstanding instruction requests, FIFO of results.
// Latency: data_ok in cycle N -> valid_out in cycle N+1; misaligned PC -> exception entry next cycle.
// Backpressure: pops on valid_out && allow_in; no new request is issued while the FIFO is full.
// Ports: aclk, aresetn (sync, active-low), redirect_valid/redirect_pc, bus (fetch_stage_if.master).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h03400000
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          discard_q, discard_d;

    logic          push;
    fetch_entry_t  push_dat;
    logic          pop;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          room;

    assign room = (count < CW'(DEPTH));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        push       = 1'b0;
        push_dat   = '0;

        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (room) begin
                    if (pc_q[1:0] == 2'b00) begin
                        req_addr_d = pc_q;
                        state_d    = ST_REQ;
                    end else begin
                        // Misaligned fetch: report ADEF without touching the bus, then park.
                        push            = 1'b1;
                        push_dat.pc     = pc_q;
                        push_dat.inst   = NOP_INST;
                        push_dat.is_exc = 1'b1;
                        push_dat.ecode  = ECODE_ADEF;
                        state_d         = ST_HALT;
                    end
                end
            end

            ST_REQ: begin
                // The request is held until accepted even after a redirect; its
                // response is then marked for discard.
                if (redirect_valid) begin
                    pc_d      = redirect_pc;
                    discard_d = 1'b1;
                end else if (bus.inst_addr_ok && !discard_q) begin
                    pc_d = pc_q + 32'd4;
                end
                // With discard set, pc already holds the redirect target: no increment.
                if (bus.inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (bus.inst_data_ok) begin
                    push            = !discard_q && !redirect_valid;
                    push_dat.pc     = req_addr_q;
                    push_dat.inst   = bus.inst_rdata;
                    push_dat.is_exc = 1'b0;
                    push_dat.ecode  = 6'h00;
                    discard_d       = 1'b0;
                    state_d         = ST_IDLE;
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end

            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pop = bus.valid_out && bus.allow_in;

    fetch_stage_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (redirect_valid),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign bus.inst_req   = (state_q == ST_REQ);
    assign bus.inst_addr  = req_addr_q;
    assign bus.valid_out  = (count != '0);
    assign bus.out_pc     = head.pc;
    assign bus.out_inst   = head.inst;
    assign bus.out_is_exc = head.is_exc;
    assign bus.out_ecode  = head.ecode;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [31:0] XOR_K  = 32'hA5A5A5A5;

    logic        aclk           = 1'b0;
    logic        aresetn        = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h1c000000),
        .DEPTH    (2),
        .NOP_INST (32'h03400000)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Bus model controls and state
    int          addr_dly  = 1;
    int          data_dly  = 0;
    logic [31:0] dead_addr = 32'hFFFF_FFFF;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] acc_addr;
    int          rcnt;
    int          dcnt;

    // Monitor records
    fetch_entry_t pop_q[$];
    logic [31:0]  acc_q[$];
    logic [31:0]  watch_addr = 32'hFFFF_FFFF;
    int           watch_cnt  = 0;
    int           dead_cnt   = 0;
    fetch_entry_t mon_e;

    // Instruction bus slave: addr_ok after addr_dly cycles of req, data_ok data_dly cycles after accept.
    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        pend = 1'b0; pend_addr = 32'h0; acc_addr = 32'h0; rcnt = 0; dcnt = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                bus.inst_addr_ok = 1'b0;
                bus.inst_data_ok = 1'b0;
                pend = 1'b0; rcnt = 0; dcnt = 0;
            end else begin
                bus.inst_data_ok = 1'b0;
                if (bus.inst_addr_ok) begin
                    pend = 1'b1; pend_addr = acc_addr; dcnt = 0;
                    bus.inst_addr_ok = 1'b0;
                end
                if (pend) begin
                    if (dcnt >= data_dly) begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = (pend_addr == dead_addr) ? 32'hDEADBEEF : (pend_addr ^ XOR_K);
                        pend = 1'b0;
                    end else begin
                        dcnt++;
                    end
                end
                if (bus.inst_req && !pend && !bus.inst_data_ok) begin
                    if (rcnt >= addr_dly) begin
                        bus.inst_addr_ok = 1'b1; acc_addr = bus.inst_addr; rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.valid_out && bus.allow_in && !redirect_valid) begin
                mon_e.pc = bus.out_pc; mon_e.inst = bus.out_inst;
                mon_e.is_exc = bus.out_is_exc; mon_e.ecode = bus.out_ecode;
                pop_q.push_back(mon_e);
                if (bus.out_inst == 32'hDEADBEEF) dead_cnt++;
            end
            if (bus.inst_req && bus.inst_addr_ok) acc_q.push_back(bus.inst_addr);
            if (bus.inst_req && bus.inst_addr == watch_addr) watch_cnt++;
        end
    end

    task automatic test_reset();
        aresetn = 1'b0;
        bus.allow_in = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL reset_inst_req got=%b want=0", bus.inst_req); end
        total++; if (bus.inst_addr !== 32'h0) begin bad++; $display("FAIL reset_inst_addr got=%h want=0", bus.inst_addr); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b want=0", bus.valid_out); end
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", bus.out_pc); end
        total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%h want=0", bus.out_inst); end
        total++; if (bus.out_is_exc !== 1'b0) begin bad++; $display("FAIL reset_out_is_exc got=%b want=0", bus.out_is_exc); end
        total++; if (bus.out_ecode !== 6'h0) begin bad++; $display("FAIL reset_out_ecode got=%h want=0", bus.out_ecode); end
    endtask

    task automatic test_sequential();
        bit found = 0;
        int base;
        logic [31:0] exp_pc;
        addr_dly = 1; data_dly = 0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        base = pop_q.size();
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge aclk);
            if (bus.inst_data_ok) found = 1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL seq_first_data_ok got=timeout want=data_ok");
        end else begin
            total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL seq_valid_same_cycle got=%b want=0", bus.valid_out); end
            @(negedge aclk);
            total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL seq_valid_next_cycle got=%b want=1", bus.valid_out); end
            total++; if (bus.out_pc !== RST_PC) begin bad++; $display("FAIL seq_first_pc got=%h want=%h", bus.out_pc, RST_PC); end
        end
        for (int i = 0; i < 100 && pop_q.size() < base + 3; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 3) begin
            bad++; $display("FAIL seq_count got=%0d want>=3", pop_q.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_pc = RST_PC + 32'(4 * k);
                total++; if (pop_q[base+k].pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h want=%h", k, pop_q[base+k].pc, exp_pc); end
                total++; if (pop_q[base+k].inst !== (exp_pc ^ XOR_K)) begin bad++; $display("FAIL seq_inst[%0d] got=%h want=%h", k, pop_q[base+k].inst, exp_pc ^ XOR_K); end
                total++; if (pop_q[base+k].is_exc !== 1'b0) begin bad++; $display("FAIL seq_exc[%0d] got=%b want=0", k, pop_q[base+k].is_exc); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] last;
        int base;
        @(posedge aclk); #1;
        bus.allow_in = 1'b0;
        last = (pop_q.size() > 0) ? pop_q[pop_q.size()-1].pc : 32'h0;
        repeat (12) @(posedge aclk);
        @(negedge aclk);
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", bus.valid_out); end
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL bp_hold_req got=%b want=0", bus.inst_req); end
        total++; if (bus.out_pc !== last + 32'd4) begin bad++; $display("FAIL bp_hold_head got=%h want=%h", bus.out_pc, last + 32'd4); end
        @(posedge aclk); #1;
        bus.allow_in = 1'b1;
        base = pop_q.size();
        @(negedge aclk);
        @(negedge aclk);
        total++; if (bus.valid_out !== 1'b1 || bus.out_pc !== last + 32'd8) begin bad++; $display("FAIL bp_second got=%b/%h want=1/%h", bus.valid_out, bus.out_pc, last + 32'd8); end
        @(negedge aclk);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", bus.valid_out); end
        for (int i = 0; i < 100 && pop_q.size() < base + 3; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 3) begin
            bad++; $display("FAIL bp_count got=%0d want>=3", pop_q.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (pop_q[base+k].pc !== last + 32'(4 * (k + 1))) begin bad++; $display("FAIL bp_order[%0d] got=%h want=%h", k, pop_q[base+k].pc, last + 32'(4 * (k + 1))); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        int base;
        int dead0;
        data_dly = 3;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge aclk);
            if (bus.inst_req && bus.inst_addr_ok) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rw_accept got=timeout want=addr_ok"); end
        @(posedge aclk); #1;
        dead_addr = bus.inst_addr;
        dead0 = dead_cnt;
        redirect_valid = 1'b1; redirect_pc = 32'h1c001000;
        base = pop_q.size();
        @(posedge aclk); #1;
        redirect_valid = 1'b0;
        @(negedge aclk);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rw_flushed got=%b want=0", bus.valid_out); end
        for (int i = 0; i < 100 && pop_q.size() < base + 2; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 2) begin
            bad++; $display("FAIL rw_count got=%0d want>=2", pop_q.size() - base);
        end else begin
            total++; if (pop_q[base].pc !== 32'h1c001000) begin bad++; $display("FAIL rw_pc0 got=%h want=1c001000", pop_q[base].pc); end
            total++; if (pop_q[base].inst !== (32'h1c001000 ^ XOR_K)) begin bad++; $display("FAIL rw_inst0 got=%h want=%h", pop_q[base].inst, 32'h1c001000 ^ XOR_K); end
            total++; if (pop_q[base+1].pc !== 32'h1c001004) begin bad++; $display("FAIL rw_pc1 got=%h want=1c001004", pop_q[base+1].pc); end
        end
        total++; if (dead_cnt != dead0) begin bad++; $display("FAIL rw_deadbeef got=%0d want=0", dead_cnt - dead0); end
        data_dly = 1;
    endtask

    task automatic test_redirect_same_cycle(input bit on_data, input logic [31:0] tgt);
        bit found = 0;
        int base, abase, w0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge aclk); #2;
            if (on_data ? bus.inst_data_ok : (bus.inst_req && bus.inst_addr_ok)) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rs_trigger[%0d] got=timeout want=handshake", on_data); end
        watch_addr = bus.inst_addr + 32'd4;
        w0 = watch_cnt;
        redirect_valid = 1'b1; redirect_pc = tgt;
        base = pop_q.size();
        @(posedge aclk); #2;
        redirect_valid = 1'b0;
        abase = acc_q.size();
        for (int i = 0; i < 100 && pop_q.size() < base + 1; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 1 || acc_q.size() < abase + 1) begin
            bad++; $display("FAIL rs_resume[%0d] got=%0d want>=1", on_data, pop_q.size() - base);
        end else begin
            total++; if (pop_q[base].pc !== tgt) begin bad++; $display("FAIL rs_pc[%0d] got=%h want=%h", on_data, pop_q[base].pc, tgt); end
            total++; if (pop_q[base].inst !== (tgt ^ XOR_K)) begin bad++; $display("FAIL rs_inst[%0d] got=%h want=%h", on_data, pop_q[base].inst, tgt ^ XOR_K); end
            total++; if (acc_q[abase] !== tgt) begin bad++; $display("FAIL rs_addr[%0d] got=%h want=%h", on_data, acc_q[abase], tgt); end
        end
        total++; if (watch_cnt != w0) begin bad++; $display("FAIL rs_old_pc4[%0d] got=%0d want=0", on_data, watch_cnt - w0); end
        watch_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_misaligned();
        int base, req_seen;
        @(posedge aclk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h1c000002;
        base = pop_q.size();
        @(posedge aclk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 60 && pop_q.size() < base + 1; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 1) begin
            bad++; $display("FAIL mis_entry got=none want=exception");
        end else begin
            total++; if (pop_q[base].pc !== 32'h1c000002) begin bad++; $display("FAIL mis_pc got=%h want=1c000002", pop_q[base].pc); end
            total++; if (pop_q[base].inst !== 32'h03400000) begin bad++; $display("FAIL mis_inst got=%h want=03400000", pop_q[base].inst); end
            total++; if (pop_q[base].is_exc !== 1'b1) begin bad++; $display("FAIL mis_is_exc got=%b want=1", pop_q[base].is_exc); end
            total++; if (pop_q[base].ecode !== 6'h08) begin bad++; $display("FAIL mis_ecode got=%h want=08", pop_q[base].ecode); end
        end
        req_seen = 0;
        repeat (6) begin
            @(negedge aclk);
            if (bus.inst_req) req_seen++;
        end
        total++; if (req_seen != 0) begin bad++; $display("FAIL mis_halt_req got=%0d want=0", req_seen); end
        total++; if (pop_q.size() != base + 1) begin bad++; $display("FAIL mis_single got=%0d want=1", pop_q.size() - base); end
        @(posedge aclk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h1c000010;
        base = pop_q.size();
        @(posedge aclk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 60 && pop_q.size() < base + 1; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 1) begin
            bad++; $display("FAIL mis_resume got=none want=entry");
        end else begin
            total++; if (pop_q[base].pc !== 32'h1c000010 || pop_q[base].is_exc !== 1'b0) begin bad++; $display("FAIL mis_resume_pc got=%h/%b want=1c000010/0", pop_q[base].pc, pop_q[base].is_exc); end
            total++; if (pop_q[base].inst !== (32'h1c000010 ^ XOR_K)) begin bad++; $display("FAIL mis_resume_inst got=%h want=%h", pop_q[base].inst, 32'h1c000010 ^ XOR_K); end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int base, abase;
        data_dly = 4;
        @(posedge aclk); #1;
        bus.allow_in = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge aclk);
            if (bus.valid_out && bus.inst_req && bus.inst_addr_ok) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rm_setup got=timeout want=wait_with_entry"); end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", bus.valid_out); end
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", bus.inst_req); end
        total++; if (bus.inst_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h want=0", bus.inst_addr); end
        @(posedge aclk); #1;
        data_dly = 0;
        bus.allow_in = 1'b1;
        aresetn = 1'b1;
        base = pop_q.size();
        abase = acc_q.size();
        for (int i = 0; i < 60 && pop_q.size() < base + 1; i++) @(negedge aclk);
        total++;
        if (pop_q.size() < base + 1 || acc_q.size() < abase + 1) begin
            bad++; $display("FAIL rm_restart got=none want=entry");
        end else begin
            total++; if (acc_q[abase] !== RST_PC) begin bad++; $display("FAIL rm_first_addr got=%h want=%h", acc_q[abase], RST_PC); end
            total++; if (pop_q[base].pc !== RST_PC) begin bad++; $display("FAIL rm_first_pc got=%h want=%h", pop_q[base].pc, RST_PC); end
        end
    endtask

    initial begin
        bus.allow_in = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle(1'b1, 32'h1c002000);
        test_redirect_same_cycle(1'b0, 32'h1c003000);
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
